// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg
//  Shared types for the writeback arbiter slice: slot-select encodings,
//  starvation FSM states and default datapath widths.
package writeback_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT           = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned STARVE_CNT_W           = 8;

  // Which source owns the register-file write slot this cycle.
  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_PIPE = 2'd1,
    WB_SEL_FIFO = 2'd2
  } wb_sel_e;

  typedef enum logic {
    STARVE_RUN   = 1'b0,
    STARVE_STEAL = 1'b1
  } starve_state_e;

endpackage

// File: rtl/writeback_fifo.sv
// writeback_fifo
//  Small synchronous FIFO holding {rd, data} long-unit results.
//  Ports:
//   i_Clock, i_Reset_N   clock, async active-low reset (empties the FIFO)
//   i_Push, i_Push_Data  write an entry (ignored when full, even if popping)
//   i_Pop                retire the head entry (ignored when empty)
//   o_Full, o_Empty      occupancy flags
//   o_Head               current head entry
module writeback_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             i_Clock,
  input  logic             i_Reset_N,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Push_Data,
  input  logic             i_Pop,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [WIDTH-1:0] o_Head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign o_Full  = (count == CNT_W'(DEPTH));
  assign o_Empty = (count == '0);
  assign o_Head  = mem[rd_ptr];
  assign do_push = i_Push && !o_Full;
  assign do_pop  = i_Pop && !o_Empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= i_Push_Data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//  Single-writer front end for the register-file write port. Pipeline results
//  have priority; long-latency results queue in writeback_fifo; a starvation
//  FSM steals one pipeline slot when the FIFO head has waited STARVE_LIMIT cycles.
//  Ports:
//   i_Clock, i_Reset_N               clock, async active-low reset
//   i_Enable                         low freezes all state, no write issued
//   i_Pipe_Valid/Reg_Write/Rd/Data   in-order pipeline result
//   o_Pipe_Stall                     slot stolen; upstream re-presents next cycle
//   i_Long_Valid/Rd/Data, o_Long_Ready  long-unit result handshake
//   o_Write_Enable/Addr/Data         registered register-file write
//   o_Long_Busy                      FIFO non-empty
//  Optional: define WRITEBACK_PERF_COUNTERS_EN to add o_Pipe_Write_Count,
//  o_Long_Write_Count and o_Steal_Count (32-bit, wrapping).
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned XLEN            = XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEFAULT,
  parameter int unsigned LONG_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Enable,
  input  logic                      i_Pipe_Valid,
  input  logic                      i_Pipe_Reg_Write,
  input  logic [REG_ADDR_WIDTH-1:0] i_Pipe_Rd,
  input  logic [XLEN-1:0]           i_Pipe_Data,
  output logic                      o_Pipe_Stall,
  input  logic                      i_Long_Valid,
  output logic                      o_Long_Ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_Long_Rd,
  input  logic [XLEN-1:0]           i_Long_Data,
  output logic                      o_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
  output logic [XLEN-1:0]           o_Write_Data,
  output logic                      o_Long_Busy
`ifdef WRITEBACK_PERF_COUNTERS_EN
  ,
  output logic [31:0]               o_Pipe_Write_Count,
  output logic [31:0]               o_Long_Write_Count,
  output logic [31:0]               o_Steal_Count
`endif
);

  localparam int unsigned ENTRY_W = REG_ADDR_WIDTH + XLEN;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ENTRY_W-1:0]        fifo_head;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [XLEN-1:0]           head_data;
  logic                      push;
  logic                      pop;
  logic                      pipe_write;
  wb_sel_e                   sel;
  starve_state_e             state, state_next;
  logic [STARVE_CNT_W-1:0]   starve_cnt, starve_cnt_next;

  assign {head_rd, head_data} = fifo_head;
  assign o_Pipe_Stall = (state == STARVE_STEAL);
  assign o_Long_Ready = !fifo_full;
  assign o_Long_Busy  = !fifo_empty;
  assign pipe_write   = i_Pipe_Valid && i_Pipe_Reg_Write && !o_Pipe_Stall;
  assign push         = i_Enable && i_Long_Valid && !fifo_full;
  assign pop          = i_Enable && (sel == WB_SEL_FIFO);

  writeback_fifo #(
    .DEPTH (LONG_FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Reset_N   (i_Reset_N),
    .i_Push      (push),
    .i_Push_Data ({i_Long_Rd, i_Long_Data}),
    .i_Pop       (pop),
    .o_Full      (fifo_full),
    .o_Empty     (fifo_empty),
    .o_Head      (fifo_head)
  );

  always_comb begin
    sel = WB_SEL_NONE;
    if (o_Pipe_Stall && !fifo_empty) sel = WB_SEL_FIFO;
    else if (pipe_write)             sel = WB_SEL_PIPE;
    else if (!fifo_empty)            sel = WB_SEL_FIFO;
  end

  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    if (i_Enable) begin
      if (state == STARVE_STEAL) begin
        state_next      = STARVE_RUN;
        starve_cnt_next = '0;
      end else if (fifo_empty || sel == WB_SEL_FIFO) begin
        starve_cnt_next = '0;
      end else if (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT - 1)) begin
        state_next      = STARVE_STEAL;
        starve_cnt_next = '0;
      end else begin
        starve_cnt_next = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state      <= STARVE_RUN;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // rd 0 still consumes its slot; only the write strobe is suppressed.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      o_Write_Enable <= 1'b0;
      o_Write_Addr   <= '0;
      o_Write_Data   <= '0;
    end else if (!i_Enable) begin
      o_Write_Enable <= 1'b0;
    end else begin
      case (sel)
        WB_SEL_PIPE: begin
          o_Write_Enable <= |i_Pipe_Rd;
          o_Write_Addr   <= i_Pipe_Rd;
          o_Write_Data   <= i_Pipe_Data;
        end
        WB_SEL_FIFO: begin
          o_Write_Enable <= |head_rd;
          o_Write_Addr   <= head_rd;
          o_Write_Data   <= head_data;
        end
        default: o_Write_Enable <= 1'b0;
      endcase
    end
  end

`ifdef WRITEBACK_PERF_COUNTERS_EN
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      o_Pipe_Write_Count <= '0;
      o_Long_Write_Count <= '0;
      o_Steal_Count      <= '0;
    end else if (i_Enable) begin
      if (sel == WB_SEL_PIPE && |i_Pipe_Rd) o_Pipe_Write_Count <= o_Pipe_Write_Count + 1'b1;
      if (sel == WB_SEL_FIFO && |head_rd)   o_Long_Write_Count <= o_Long_Write_Count + 1'b1;
      if (o_Pipe_Stall)                     o_Steal_Count      <= o_Steal_Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pv, prw;
  logic [4:0]  prd;
  logic [31:0] pdata;
  logic        stall;
  logic        lv, lready;
  logic [4:0]  lrd;
  logic [31:0] ldata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .XLEN            (32),
    .REG_ADDR_WIDTH  (5),
    .LONG_FIFO_DEPTH (2),
    .STARVE_LIMIT    (8)
  ) dut (
    .i_Clock          (clk),
    .i_Reset_N        (rst_n),
    .i_Enable         (en),
    .i_Pipe_Valid     (pv),
    .i_Pipe_Reg_Write (prw),
    .i_Pipe_Rd        (prd),
    .i_Pipe_Data      (pdata),
    .o_Pipe_Stall     (stall),
    .i_Long_Valid     (lv),
    .o_Long_Ready     (lready),
    .i_Long_Rd        (lrd),
    .i_Long_Data      (ldata),
    .o_Write_Enable   (we),
    .o_Write_Addr     (waddr),
    .o_Write_Data     (wdata),
    .o_Long_Busy      (busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        pv;
    logic        prw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic w, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.we = w;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock edge and compare the registered write against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow: actual=empty required=entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("wr_en", 32'(we), 32'(e.we));
      if (e.we) begin
        check("wr_addr", 32'(waddr), 32'(e.addr));
        check("wr_data", wdata, e.data);
      end
    end
  endtask

  task automatic pipe(input logic v, input logic w, input logic [4:0] r, input logic [31:0] d);
    pv = v;
    prw = w;
    prd = r;
    pdata = d;
  endtask

  task automatic long_in(input logic v, input logic [4:0] r, input logic [31:0] d);
    lv = v;
    lrd = r;
    ldata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int li;
    int pi;
    logic st_exp;
    logic rdy_exp;
    logic en_k;
    logic [4:0]  lrds[3];
    logic [31:0] ldats[3];

    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b1, 1'b0, 5'd9,  32'hCAFEF00D, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b0, 1'b1, 5'd9,  32'h0BADC0DE, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    vecs[6] = '{1'b1, 1'b1, 5'd5,  32'hFFFFFFFF, 1'b1, 5'd5,  32'hFFFFFFFF};
    lrds[0] = 5'd10; lrds[1] = 5'd11; lrds[2] = 5'd12;
    ldats[0] = 32'hA0A0_0010; ldats[1] = 32'hB0B0_0011; ldats[2] = 32'hC0C0_0012;

    // Reset state
    rst_n = 1'b0;
    en = 1'b1;
    pipe(1'b0, 1'b0, 5'd0, 32'h0);
    long_in(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(waddr), 32'd0);
    check("rst_data", wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ready", 32'(lready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_wr(1'b0, 5'd0, 32'h0);
    tick();

    // Pipeline-only vectors
    foreach (vecs[i]) begin
      pipe(vecs[i].pv, vecs[i].prw, vecs[i].rd, vecs[i].data);
      expect_wr(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();
    end

    // Long result into an idle pipeline: written two edges after the push
    pipe(1'b0, 1'b0, 5'd0, 32'h0);
    check("idle_ready", 32'(lready), 32'd1);
    long_in(1'b1, 5'd7, 32'h1234);
    expect_wr(1'b0, 5'd0, 32'h0);
    tick();
    check("idle_busy_t1", 32'(busy), 32'd1);
    long_in(1'b0, 5'd0, 32'h0);
    expect_wr(1'b1, 5'd7, 32'h1234);
    tick();
    check("idle_busy_t2", 32'(busy), 32'd0);
    long_in(1'b1, 5'd0, 32'h5555);
    expect_wr(1'b0, 5'd0, 32'h0);
    tick();
    check("rd0_busy", 32'(busy), 32'd1);
    long_in(1'b0, 5'd0, 32'h0);
    expect_wr(1'b0, 5'd0, 32'h0);
    tick();
    check("rd0_busy_after", 32'(busy), 32'd0);
    expect_wr(1'b0, 5'd0, 32'h0);
    tick();

    // Fill with a busy pipeline, then three slot steals retire A, B, C in order
    p = 0; li = 0; pi = 0;
    for (int k = 0; k < 30; k++) begin
      st_exp  = (k == 9) || (k == 18) || (k == 27);
      rdy_exp = (k < 2) || (k == 10);
      check("fill_stall", 32'(stall), 32'(st_exp));
      pipe(1'b1, 1'b1, 5'd3, 32'h1000 + 32'(p));
      if (li < 3) begin
        long_in(1'b1, lrds[li], ldats[li]);
        check("fill_ready", 32'(lready), 32'(rdy_exp));
      end else begin
        long_in(1'b0, 5'd0, 32'h0);
      end
      if (st_exp) begin
        expect_wr(1'b1, lrds[pi], ldats[pi]);
        pi++;
      end else begin
        expect_wr(1'b1, 5'd3, 32'h1000 + 32'(p));
        p++;
      end
      if (li < 3 && rdy_exp) li++;
      tick();
    end
    check("fill_busy_end", 32'(busy), 32'd0);

    // Enable freeze: counter holds for 3 cycles, and the stall holds across a frozen steal cycle
    p = 0;
    for (int k = 0; k < 16; k++) begin
      en_k   = !((k >= 4 && k <= 6) || k == 12);
      st_exp = (k == 12) || (k == 13);
      check("en_stall", 32'(stall), 32'(st_exp));
      en = en_k;
      pipe(1'b1, 1'b1, 5'd4, 32'h2000 + 32'(p));
      long_in(k == 0, 5'd20, 32'hBEEF0020);
      if (!en_k) begin
        expect_wr(1'b0, 5'd0, 32'h0);
      end else if (st_exp) begin
        expect_wr(1'b1, 5'd20, 32'hBEEF0020);
      end else begin
        expect_wr(1'b1, 5'd4, 32'h2000 + 32'(p));
        p++;
      end
      tick();
      check("en_busy", 32'(busy), 32'(k < 13));
    end
    en = 1'b1;

    // Async reset in the middle of a steal with two entries queued
    p = 0;
    for (int k = 0; k < 9; k++) begin
      check("ar_stall_pre", 32'(stall), 32'd0);
      pipe(1'b1, 1'b1, 5'd6, 32'h3000 + 32'(p));
      long_in(k < 2, 5'(13 + k), 32'hE000 + 32'(k));
      expect_wr(1'b1, 5'd6, 32'h3000 + 32'(p));
      p++;
      tick();
    end
    check("ar_stall_mid", 32'(stall), 32'd1);
    check("ar_busy_mid", 32'(busy), 32'd1);
    check("ar_ready_mid", 32'(lready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we", 32'(we), 32'd0);
    check("ar_addr", 32'(waddr), 32'd0);
    check("ar_data", wdata, 32'd0);
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_ready", 32'(lready), 32'd1);
    check("ar_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pipe(1'b0, 1'b0, 5'd0, 32'h0);
    long_in(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_wr(1'b0, 5'd0, 32'h0);
      tick();
      check("post_rst_stall", 32'(stall), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
